// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared encodings and decode helpers for the load/store unit. rev 1.0
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Unused encodings (011, 110, 111) fall through to word.
  function automatic lsu_size_t decode_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (decode_size(f3))
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align -- combinational store-lane replication/strobes and load extraction/extension. rev 1.0
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  lsu_size_t   size;
  logic        zext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    size      = decode_size(funct3);
    zext      = (funct3 == F3_BU) || (funct3 == F3_HU);
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase

    wdata     = store_data;
    wstrb     = STRB_W;
    load_data = rdata;
    case (size)
      SZ_B: begin
        wdata     = {4{store_data[7:0]}};
        wstrb     = STRB_B << addr_lo;
        load_data = {{24{~zext & byte_lane[7]}}, byte_lane};
      end
      SZ_H: begin
        wdata     = {2{store_data[15:0]}};
        wstrb     = STRB_H << {addr_lo[1], 1'b0};
        load_data = {{16{~zext & half_lane[15]}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit -- MEM-stage data-bus master with pipeline stall, timeout and alignment. rev 1.0
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [31:0]           ALU_ResultM,
  input  logic [31:0]           WriteDataM,
  output logic                  StallM,
  output logic [31:0]           ReadDataW,
  output logic                  MisalignedM,
  output logic                  BusErrM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;

  logic        access;
  logic        misaligned;
  logic        timed_out;
  logic [2:0]  align_f3;
  logic [1:0]  align_lo;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic [3:0]  align_wstrb;

  assign access     = MemReadM | MemWriteM;
  assign misaligned = is_misaligned(funct3M, ALU_ResultM[1:0]);

  // Stores are shaped from live inputs in IDLE; loads use the latched request in BUSY.
  assign align_f3 = (state == S_IDLE) ? funct3M : funct3_q;
  assign align_lo = (state == S_IDLE) ? ALU_ResultM[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3     (align_f3),
    .addr_lo    (align_lo),
    .store_data (WriteDataM),
    .rdata      (mem_rdata),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .load_data  (align_load)
  );

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timed_out = (count == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timed_out = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && !misaligned) begin
          StallM     = 1'b1;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        StallM = 1'b1;
        if (mem_ready || timed_out) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      ReadDataW   <= '0;
      MisalignedM <= 1'b0;
      BusErrM     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
    end else begin
      state       <= state_next;
      MisalignedM <= (state == S_IDLE) && access && misaligned;
      BusErrM     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access && !misaligned) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALU_ResultM[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= align_wdata;
            mem_wstrb <= MemWriteM ? align_wstrb : STRB_NONE;
            funct3_q  <= funct3M;
            addr_lo_q <= ALU_ResultM[1:0];
            count     <= '0;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadDataW <= align_load;
          end else if (timed_out) begin
            mem_req <= 1'b0;
            BusErrM <= 1'b1;
            if (!mem_we) ReadDataW <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed vector table plus randomized accesses against a byte-level model. rev 1.0
`default_nettype none

module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALU_ResultM, WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataW;
  logic        MisalignedM, BusErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataW(ReadDataW), .MisalignedM(MisalignedM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ready_at;
    logic        we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rd;
    logic        mis;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = rdata >> (8 * off);
    if (n == 1) begin
      v = v % 256;
      if (f3 < 3'd4 && v >= 128) v = v - 32'd256;
    end else if (n == 2) begin
      v = v % 65536;
      if (f3 < 3'd4 && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                            input int ready_at, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                            input logic [31:0] exp_rd, input logic exp_mis);
    int   stalls;
    int   k;
    logic exp_err;
    exp_err = !exp_mis && (ready_at >= TMO);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALU_ResultM = addr; WriteDataM = wd;
    mem_ready = 1'b0;
    #1;
    check("stall_on_issue", StallM, !exp_mis);
    if (exp_mis) begin
      @(posedge clk); #1;
      idle_inputs();
      #1;
      check("misaligned_pulse", MisalignedM, 1);
      check("misaligned_no_req", mem_req, 0);
      check("misaligned_no_stall", StallM, 0);
      @(posedge clk); #2;
      check("misaligned_one_cycle", MisalignedM, 0);
      check("misaligned_rd_held", ReadDataW, exp_rd);
      return;
    end
    stalls = 1;
    k = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = (k == ready_at);
      mem_rdata = (k == ready_at) ? rdata : $urandom;
      #1;
      if (StallM) stalls++;
      if (k == 0) begin
        check("busy_req", mem_req, 1);
        check("busy_we", mem_we, exp_we);
        check("busy_addr", mem_addr, exp_addr);
        check("busy_wstrb", mem_wstrb, exp_wstrb);
        if (exp_we) check("busy_wdata", mem_wdata, exp_wdata);
      end
      if (mem_ready || k == TMO - 1 || k >= 200) break;
      k++;
    end
    check("busy_addr_held", mem_addr, exp_addr);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    check("done_stall_low", StallM, 0);
    check("done_req_low", mem_req, 0);
    check("done_buserr", BusErrM, exp_err);
    check("done_readdata", ReadDataW, exp_rd);
    check("stall_cycles", stalls, exp_err ? TMO + 1 : ready_at + 2);
    idle_inputs();
    @(posedge clk); #2;
    check("after_buserr_low", BusErrM, 0);
    check("after_rd_held", ReadDataW, exp_rd);
    check("after_req_low", mem_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rd, wr, mis;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata, ewdata, model_rd;
    logic [3:0]  ewstrb;
    int          ready_at, n, off;

    //            rd    wr    f3      addr          wd            rdata         rdy we    exp_addr      exp_wdata     strb     exp_rd        mis
    tbl[0]  = '{1'b1, 1'b0, F3_W,   32'h100, 32'h0,        32'hDEADBEEF, 0,  1'b0, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, F3_B,   32'h103, 32'h0,        32'h80FF7F01, 0,  1'b0, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, F3_BU,  32'h103, 32'h0,        32'h80FF7F01, 1,  1'b0, 32'h100, 32'h0,        4'b0000, 32'h00000080, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, F3_HU,  32'h102, 32'h0,        32'h80FF7F01, 0,  1'b0, 32'h100, 32'h0,        4'b0000, 32'h000080FF, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, F3_B,   32'h201, 32'h12345678, 32'h0,        0,  1'b1, 32'h200, 32'h78787878, 4'b0010, 32'h000080FF, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, F3_H,   32'h202, 32'h12345678, 32'h0,        2,  1'b1, 32'h200, 32'h56785678, 4'b1100, 32'h000080FF, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, F3_W,   32'h101, 32'h0,        32'h0,        0,  1'b0, 32'h100, 32'h0,        4'b0000, 32'h000080FF, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, F3_H,   32'h102, 32'h0,        32'h80010000, 3,  1'b0, 32'h100, 32'h0,        4'b0000, 32'hFFFF8001, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, F3_W,   32'h30C, 32'hCAFEBABE, 32'h0,        0,  1'b1, 32'h30C, 32'hCAFEBABE, 4'b1111, 32'hFFFF8001, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, F3_W,   32'h040, 32'h0,        32'h0,        99, 1'b0, 32'h040, 32'h0,        4'b0000, 32'h00000000, 1'b0};
    tbl[10] = '{1'b1, 1'b1, F3_W,   32'h050, 32'h11223344, 32'h0,        0,  1'b1, 32'h050, 32'h11223344, 4'b1111, 32'h00000000, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'b011, 32'h060, 32'h0,        32'h12345678, 1,  1'b0, 32'h060, 32'h0,        4'b0000, 32'h12345678, 1'b0};
    tbl[12] = '{1'b0, 1'b1, F3_H,   32'h203, 32'h0,        32'h0,        0,  1'b1, 32'h200, 32'h0,        4'b0000, 32'h12345678, 1'b1};

    rst = 1'b1;
    idle_inputs();
    funct3M = 3'b0; ALU_ResultM = '0; WriteDataM = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_readdata", ReadDataW, 0);
    check("reset_req", mem_req, 0);
    check("reset_we", mem_we, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    check("reset_wstrb", mem_wstrb, 0);
    check("reset_misaligned", MisalignedM, 0);
    check("reset_buserr", BusErrM, 0);
    check("reset_stall", StallM, 0);

    for (int i = 0; i < 13; i++)
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdata,
                 tbl[i].ready_at, tbl[i].we, tbl[i].exp_addr, tbl[i].exp_wdata,
                 tbl[i].exp_wstrb, tbl[i].exp_rd, tbl[i].mis);

    // Reset during the third BUSY cycle, then a stray ready.
    @(posedge clk); #1;
    MemReadM = 1'b1; funct3M = F3_W; ALU_ResultM = 32'h80; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mid_busy_req", mem_req, 1);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_req_clear", mem_req, 0);
    check("rst_mid_stall", StallM, 0);
    check("rst_mid_rd_clear", ReadDataW, 0);
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    check("late_ready_rd", ReadDataW, 0);
    check("late_ready_req", mem_req, 0);
    check("late_ready_stall", StallM, 0);
    model_rd = 32'h0;

    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom % 32'h10000;
      wd = $urandom;
      rdata = $urandom;
      ready_at = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      n = nbytes(f3);
      off = int'(addr % 4);
      mis = (off % n) != 0;
      ewstrb = wr ? 4'(((1 << n) - 1) << off) : 4'b0000;
      if (n == 1) ewdata = (wd % 256) * 32'h01010101;
      else if (n == 2) ewdata = (wd % 65536) * 32'h00010001;
      else ewdata = wd;
      if (!mis && !wr) model_rd = (ready_at < TMO) ? load_model(f3, off, rdata) : 32'h0;
      run_access(rd, wr, f3, addr, wd, rdata, ready_at, wr, addr - 32'(off),
                 ewdata, ewstrb, model_rd, mis);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
